// File: rtl/uart_cfg_core_if.sv
// Slot-bus register interface for uart_cfg_core.
// The master drives the slot strobes; the slave returns combinational read data.
interface uart_cfg_core_if;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  reg_addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   modport master (output cs, read, write, reg_addr, wr_data, input rd_data);
   modport slave  (input cs, read, write, reg_addr, wr_data, output rd_data);
endinterface

// File: rtl/uart_cfg_core.sv
// MMIO UART core: 16x-oversampled TX/RX with FIFOs, programmable frame format and sticky errors.
// Optional feature: UART_LOOPBACK_EN (ctrl[4] routes the tx stream into the receiver).
module uart_cfg_core #(
   parameter int FIFO_DEPTH_BIT = 4,
   parameter int DVSR_W         = 11
) (
   input  logic           clk,
   input  logic           reset,
   uart_cfg_core_if.slave bus,
   output logic           tx,
   input  logic           rx
);
   localparam int DEPTH = 2**FIFO_DEPTH_BIT;
   localparam int LPAD  = 15 - FIFO_DEPTH_BIT;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [2:0] addr;
   logic       wr_en;
   assign addr  = bus.reg_addr[2:0];
   assign wr_en = bus.cs & bus.write;

   logic unused_bus;
   assign unused_bus = ^{bus.read, bus.reg_addr, bus.wr_data};

   logic [DVSR_W-1:0] dvsr, cnt;
`ifdef UART_LOOPBACK_EN
   logic [4:0] ctrl;
`else
   logic [3:0] ctrl;
`endif
   logic frame_err, parity_err, overrun;
   logic fe_set, pe_set, ov_set;
   logic tick, tx_bit, rx_in;

   // ---------------- baud tick ----------------
   assign tick = (cnt == dvsr);
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else       cnt <= tick ? '0 : cnt + 1'b1;

   // ---------------- FIFOs ----------------
   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];
   logic [FIFO_DEPTH_BIT:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_level, rx_level;
   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop, tx_push_ok, rx_push_ok;
   logic [7:0] tx_head, rx_head, rx_byte;

   assign tx_level = tx_wp - tx_rp;
   assign rx_level = rx_wp - rx_rp;
   assign tx_empty = (tx_level == '0);
   assign rx_empty = (rx_level == '0);
   assign tx_full  = tx_level[FIFO_DEPTH_BIT];
   assign rx_full  = rx_level[FIFO_DEPTH_BIT];
   assign tx_head  = tx_mem[tx_rp[FIFO_DEPTH_BIT-1:0]];
   assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_DEPTH_BIT-1:0]];

   assign tx_push    = wr_en && (addr == 3'd2);
   assign rx_pop     = wr_en && (addr == 3'd3) && !rx_empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign tx_push_ok = tx_push && (!tx_full || tx_pop);
   assign rx_push_ok = rx_push && (!rx_full || rx_pop);
   assign ov_set     = rx_push && rx_full && !rx_pop;

   always_ff @(posedge clk) begin
      if (tx_push_ok) tx_mem[tx_wp[FIFO_DEPTH_BIT-1:0]] <= bus.wr_data[7:0];
      if (rx_push_ok) rx_mem[rx_wp[FIFO_DEPTH_BIT-1:0]] <= rx_byte;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
      end else begin
         if (tx_push_ok) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)     tx_rp <= tx_rp + 1'b1;
         if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)     rx_rp <= rx_rp + 1'b1;
      end

   // ---------------- registers and flags ----------------
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         dvsr <= '0; ctrl <= '0;
         frame_err <= 1'b0; parity_err <= 1'b0; overrun <= 1'b0;
      end else begin
         if (wr_en && addr == 3'd1) dvsr <= bus.wr_data[DVSR_W-1:0];
`ifdef UART_LOOPBACK_EN
         if (wr_en && addr == 3'd4) ctrl <= bus.wr_data[4:0];
`else
         if (wr_en && addr == 3'd4) ctrl <= bus.wr_data[3:0];
`endif
         frame_err  <= fe_set | (frame_err  & ~(wr_en && addr == 3'd5 && bus.wr_data[0]));
         parity_err <= pe_set | (parity_err & ~(wr_en && addr == 3'd5 && bus.wr_data[1]));
         overrun    <= ov_set | (overrun    & ~(wr_en && addr == 3'd5 && bus.wr_data[2]));
      end

   always_comb begin
      bus.rd_data = '0;
      if (bus.cs)
         case (addr)
            3'd0: bus.rd_data = {19'b0, overrun, parity_err, frame_err, tx_full, rx_empty, rx_head};
`ifdef UART_LOOPBACK_EN
            3'd4: bus.rd_data = {27'b0, ctrl};
`else
            3'd4: bus.rd_data = {28'b0, ctrl};
`endif
            3'd6: bus.rd_data = {{LPAD{1'b0}}, rx_level, {LPAD{1'b0}}, tx_level};
            default: bus.rd_data = '0;
         endcase
   end

`ifdef UART_LOOPBACK_EN
   assign tx    = ctrl[4] ? 1'b1 : tx_bit;
   assign rx_in = ctrl[4] ? tx_bit : rx;
`else
   assign tx    = tx_bit;
   assign rx_in = rx;
`endif

   // ---------------- transmitter ----------------
   state_t     tx_st, tx_st_n;
   logic [4:0] tx_s, tx_s_n;
   logic [2:0] tx_n, tx_n_n;
   logic [7:0] tx_b, tx_b_n;
   logic       tx_par, tx_par_n, tx_d8, tx_d8_n, tx_pe, tx_pe_n, tx_st2, tx_st2_n;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tx_st <= IDLE; tx_s <= '0; tx_n <= '0; tx_b <= '0;
         tx_par <= 1'b0; tx_d8 <= 1'b0; tx_pe <= 1'b0; tx_st2 <= 1'b0;
      end else begin
         tx_st <= tx_st_n; tx_s <= tx_s_n; tx_n <= tx_n_n; tx_b <= tx_b_n;
         tx_par <= tx_par_n; tx_d8 <= tx_d8_n; tx_pe <= tx_pe_n; tx_st2 <= tx_st2_n;
      end

   always_comb begin
      tx_st_n = tx_st; tx_s_n = tx_s; tx_n_n = tx_n; tx_b_n = tx_b;
      tx_par_n = tx_par; tx_d8_n = tx_d8; tx_pe_n = tx_pe; tx_st2_n = tx_st2;
      tx_pop = 1'b0;
      case (tx_st)
         IDLE:
            // starting on a tick makes the start bit exactly 16 ticks long
            if (tick && !tx_empty) begin
               tx_pop = 1'b1; tx_b_n = tx_head; tx_s_n = '0; tx_n_n = '0;
               tx_d8_n = ctrl[0]; tx_pe_n = ctrl[2] ^ ctrl[1];
               tx_par_n = ctrl[2] & ~ctrl[1]; tx_st2_n = ctrl[3];
               tx_st_n = START;
            end
         START:
            if (tick) begin
               if (tx_s == 5'd15) begin tx_s_n = '0; tx_st_n = DATA; end
               else tx_s_n = tx_s + 5'd1;
            end
         DATA:
            if (tick) begin
               if (tx_s == 5'd15) begin
                  tx_s_n = '0; tx_b_n = tx_b >> 1; tx_par_n = tx_par ^ tx_b[0];
                  if (tx_n == (tx_d8 ? 3'd7 : 3'd6)) tx_st_n = tx_pe ? PARITY : STOP;
                  else tx_n_n = tx_n + 3'd1;
               end else tx_s_n = tx_s + 5'd1;
            end
         PARITY:
            if (tick) begin
               if (tx_s == 5'd15) begin tx_s_n = '0; tx_st_n = STOP; end
               else tx_s_n = tx_s + 5'd1;
            end
         STOP:
            if (tick) begin
               if (tx_s == (tx_st2 ? 5'd31 : 5'd15)) begin tx_s_n = '0; tx_st_n = IDLE; end
               else tx_s_n = tx_s + 5'd1;
            end
         default: tx_st_n = IDLE;
      endcase
   end

   always_comb
      case (tx_st)
         START:   tx_bit = 1'b0;
         DATA:    tx_bit = tx_b[0];
         PARITY:  tx_bit = tx_par;
         default: tx_bit = 1'b1;
      endcase

   // ---------------- receiver ----------------
   state_t     rx_st, rx_st_n;
   logic [4:0] rx_s, rx_s_n;
   logic [2:0] rx_n, rx_n_n;
   logic [7:0] rx_b, rx_b_n;
   logic       rx_par, rx_par_n, rx_d8, rx_d8_n, rx_pe, rx_pe_n, rx_st2, rx_st2_n;

   assign rx_byte = rx_d8 ? rx_b : {1'b0, rx_b[7:1]};

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rx_st <= IDLE; rx_s <= '0; rx_n <= '0; rx_b <= '0;
         rx_par <= 1'b0; rx_d8 <= 1'b0; rx_pe <= 1'b0; rx_st2 <= 1'b0;
      end else begin
         rx_st <= rx_st_n; rx_s <= rx_s_n; rx_n <= rx_n_n; rx_b <= rx_b_n;
         rx_par <= rx_par_n; rx_d8 <= rx_d8_n; rx_pe <= rx_pe_n; rx_st2 <= rx_st2_n;
      end

   always_comb begin
      rx_st_n = rx_st; rx_s_n = rx_s; rx_n_n = rx_n; rx_b_n = rx_b;
      rx_par_n = rx_par; rx_d8_n = rx_d8; rx_pe_n = rx_pe; rx_st2_n = rx_st2;
      rx_push = 1'b0; fe_set = 1'b0; pe_set = 1'b0;
      case (rx_st)
         IDLE:
            if (!rx_in) begin
               rx_s_n = '0; rx_n_n = '0;
               rx_d8_n = ctrl[0]; rx_pe_n = ctrl[2] ^ ctrl[1];
               rx_par_n = ctrl[2] & ~ctrl[1]; rx_st2_n = ctrl[3];
               rx_st_n = START;
            end
         START:
            if (tick) begin
               if (rx_s == 5'd7) begin
                  rx_s_n = '0;
                  rx_st_n = rx_in ? IDLE : DATA;
               end else rx_s_n = rx_s + 5'd1;
            end
         DATA:
            if (tick) begin
               if (rx_s == 5'd15) begin
                  rx_s_n = '0; rx_b_n = {rx_in, rx_b[7:1]}; rx_par_n = rx_par ^ rx_in;
                  if (rx_n == (rx_d8 ? 3'd7 : 3'd6)) rx_st_n = rx_pe ? PARITY : STOP;
                  else rx_n_n = rx_n + 3'd1;
               end else rx_s_n = rx_s + 5'd1;
            end
         PARITY:
            if (tick) begin
               if (rx_s == 5'd15) begin
                  rx_s_n = '0; pe_set = (rx_in != rx_par); rx_st_n = STOP;
               end else rx_s_n = rx_s + 5'd1;
            end
         STOP:
            // sampling is mid-bit, so STOP ends mid-way through the last stop bit
            if (tick) begin
               if (rx_s == 5'd15) fe_set = !rx_in;
               if (rx_s == (rx_st2 ? 5'd31 : 5'd15)) begin
                  rx_push = 1'b1; rx_s_n = '0; rx_st_n = IDLE;
               end else rx_s_n = rx_s + 5'd1;
            end
         default: rx_st_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_cfg_core.sv
// Directed self-checking bench for uart_cfg_core (dvsr = 3 gives 64 clocks per bit).
// Build with +define+UART_LOOPBACK_EN to exercise the loopback path.
module tb_uart_cfg_core;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx = 1'b1;
   logic tx;
   int   checks = 0;
   int   failures = 0;

   uart_cfg_core_if bus ();

   uart_cfg_core #(.FIFO_DEPTH_BIT(4), .DVSR_W(11)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .tx(tx), .rx(rx)
   );

   always #5 clk = ~clk;

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.write = 1'b1; bus.reg_addr = {2'b00, a}; bus.wr_data = d;
      @(negedge clk);
      bus.cs = 1'b0; bus.write = 1'b0;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
      bus.cs = 1'b1; bus.read = 1'b1; bus.reg_addr = {2'b00, a};
      #1 d = bus.rd_data;
      bus.cs = 1'b0; bus.read = 1'b0;
   endtask

   // 64 clocks per bit; a zero stop bit is held 40 clocks so the receiver resyncs cleanly.
   task automatic send_frame(input logic [7:0] d, input int unsigned nbits,
                             input bit has_par, input logic par, input logic stop_val);
      @(negedge clk);
      rx = 1'b0; repeat (64) @(negedge clk);
      for (int unsigned i = 0; i < nbits; i++) begin
         rx = d[i]; repeat (64) @(negedge clk);
      end
      if (has_par) begin rx = par; repeat (64) @(negedge clk); end
      rx = stop_val; repeat (stop_val ? 64 : 40) @(negedge clk);
      rx = 1'b1; repeat (64) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [31:0] r;
      reset = 1'b1; repeat (3) @(negedge clk); reset = 1'b0;
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h100) begin failures++; $display("FAIL reset_addr0: got %h expected %h", r, 32'h100); end
      bus_rd(3'd6, r); checks++;
      if (r !== 32'h0) begin failures++; $display("FAIL reset_addr6: got %h expected %h", r, 32'h0); end
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
   endtask

   task automatic test_levels_reset;
      logic [31:0] r;
      bit found = 0;
      bus_wr(3'd1, 32'd2047);
      for (int i = 0; i < 17; i++) bus_wr(3'd2, 32'(i));
      bus_rd(3'd6, r); checks++;
      if (r !== 32'h10) begin failures++; $display("FAIL tx_level_full: got %h expected %h", r, 32'h10); end
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h300) begin failures++; $display("FAIL tx_full_flag: got %h expected %h", r, 32'h300); end
      for (int i = 0; i < 2300 && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1;
      end
      checks++;
      if (!found) begin failures++; $display("FAIL slow_tx_start: got no start bit expected start within 2300 clocks"); end
      bus_rd(3'd6, r); checks++;
      if (r !== 32'h0F) begin failures++; $display("FAIL tx_level_after_pop: got %h expected %h", r, 32'h0F); end
      reset = 1'b1; #1;
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL midframe_reset_tx: got %b expected 1", tx); end
      bus_rd(3'd6, r); checks++;
      if (r !== 32'h0) begin failures++; $display("FAIL midframe_reset_levels: got %h expected %h", r, 32'h0); end
      repeat (2) @(negedge clk); reset = 1'b0;
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h100) begin failures++; $display("FAIL midframe_reset_addr0: got %h expected %h", r, 32'h100); end
   endtask

   task automatic test_tx;
      logic [31:0] r;
      logic [7:0]  exp_byte = 8'hA5;
      bit found = 0;
      bus_wr(3'd1, 32'd3);
      bus_wr(3'd4, 32'h01);
      bus_wr(3'd2, 32'hA5);
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1;
      end
      checks++;
      if (!found) begin failures++; $display("FAIL tx_start: got no start bit expected start within 200 clocks"); end
      repeat (62) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin failures++; $display("FAIL tx_start_width: got %b expected 0", tx); end
      repeat (34) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (tx !== exp_byte[i]) begin failures++; $display("FAIL tx_bit%0d: got %b expected %b", i, tx, exp_byte[i]); end
         repeat (64) @(negedge clk);
      end
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL tx_stop: got %b expected 1", tx); end
      bus_rd(3'd6, r); checks++;
      if (r !== 32'h0) begin failures++; $display("FAIL tx_level_drained: got %h expected %h", r, 32'h0); end
   endtask

   task automatic test_rx_parity;
      logic [31:0] r;
      bus_wr(3'd4, 32'h03);
      send_frame(8'h0F, 8, 1, 1'b0, 1'b1);
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h00F) begin failures++; $display("FAIL rx_parity_ok: got %h expected %h", r, 32'h00F); end
      send_frame(8'h0F, 8, 1, 1'b1, 1'b1);
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h80F) begin failures++; $display("FAIL rx_parity_bad: got %h expected %h", r, 32'h80F); end
      bus_rd(3'd6, r); checks++;
      if (r !== 32'h20000) begin failures++; $display("FAIL rx_level_two: got %h expected %h", r, 32'h20000); end
      bus_wr(3'd3, 32'h0);
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h80F) begin failures++; $display("FAIL rx_second_byte: got %h expected %h", r, 32'h80F); end
      bus_wr(3'd3, 32'h0);
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h900) begin failures++; $display("FAIL rx_drained: got %h expected %h", r, 32'h900); end
      bus_wr(3'd5, 32'h2);
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h100) begin failures++; $display("FAIL parity_w1c: got %h expected %h", r, 32'h100); end
   endtask

   task automatic test_frame_err;
      logic [31:0] r;
      bus_wr(3'd4, 32'h01);
      send_frame(8'h5A, 8, 0, 1'b0, 1'b0);
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h45A) begin failures++; $display("FAIL frame_err: got %h expected %h", r, 32'h45A); end
      bus_wr(3'd3, 32'h0);
      bus_wr(3'd5, 32'h1);
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h100) begin failures++; $display("FAIL frame_w1c: got %h expected %h", r, 32'h100); end
   endtask

   task automatic test_glitch;
      logic [31:0] r;
      @(negedge clk);
      rx = 1'b0; repeat (4) @(negedge clk);
      rx = 1'b1; repeat (200) @(negedge clk);
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h100) begin failures++; $display("FAIL glitch_addr0: got %h expected %h", r, 32'h100); end
      bus_rd(3'd6, r); checks++;
      if (r !== 32'h0) begin failures++; $display("FAIL glitch_level: got %h expected %h", r, 32'h0); end
   endtask

   task automatic test_overrun;
      logic [31:0] r;
      for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 8, 0, 1'b0, 1'b1);
      bus_rd(3'd6, r); checks++;
      if (r !== 32'h100000) begin failures++; $display("FAIL overrun_level: got %h expected %h", r, 32'h100000); end
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h1010) begin failures++; $display("FAIL overrun_flag: got %h expected %h", r, 32'h1010); end
      for (int i = 0; i < 16; i++) begin
         bus_rd(3'd0, r); checks++;
         if (r[7:0] !== 8'(8'h10 + i)) begin
            failures++; $display("FAIL overrun_byte%0d: got %h expected %h", i, r[7:0], 8'(8'h10 + i));
         end
         bus_wr(3'd3, 32'h0);
      end
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h1100) begin failures++; $display("FAIL overrun_dropped: got %h expected %h", r, 32'h1100); end
      bus_wr(3'd5, 32'h4);
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h100) begin failures++; $display("FAIL overrun_w1c: got %h expected %h", r, 32'h100); end
   endtask

   task automatic test_loopback;
      logic [31:0] r;
      bus_wr(3'd4, 32'h11);
`ifdef UART_LOOPBACK_EN
      bus_rd(3'd4, r); checks++;
      if (r !== 32'h11) begin failures++; $display("FAIL loop_ctrl: got %h expected %h", r, 32'h11); end
      begin
         int unsigned low_seen = 0;
         bus_wr(3'd2, 32'h3C);
         for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen++;
         end
         checks++;
         if (low_seen != 0) begin failures++; $display("FAIL loop_tx_pin: got %0d non-high clocks expected 0", low_seen); end
      end
      bus_rd(3'd0, r); checks++;
      if (r !== 32'h03C) begin failures++; $display("FAIL loop_rx_head: got %h expected %h", r, 32'h03C); end
`else
      bus_rd(3'd4, r); checks++;
      if (r !== 32'h01) begin failures++; $display("FAIL ctrl_no_loop: got %h expected %h", r, 32'h01); end
`endif
   endtask

   initial begin
      bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.reg_addr = '0; bus.wr_data = '0;
      test_reset();
      test_levels_reset();
      test_tx();
      test_rx_parity();
      test_frame_err();
      test_glitch();
      test_overrun();
      test_loopback();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_cfg_core.md
# uart_cfg_core

Parametrised UART MMIO core for the slot bus: self-contained 16x-oversampled transmitter and receiver, each buffered by a FIFO of configurable depth. Frame format is runtime-programmable: 7/8 data bits, parity none/even/odd, 1/2 stop bits. Sticky error flags cover frame, parity and overrun. FIFO fill levels are readable by software. The block occupies one MMIO slot alongside the other cores.

## Interface
- FIFO_DEPTH_BIT, 4, address bits of each FIFO (depth = 2**FIFO_DEPTH_BIT entries)
- DVSR_W, 11, width of the baud divisor register
---
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  slot select
- read  in  1  slot read strobe (decode does not use it; reads are side-effect free)
- write  in  1  slot write strobe
- reg_addr  in  5  register address; only [2:0] is decoded
- wr_data  in  32  write data
- rd_data  out  32  read data, combinational from reg_addr[2:0]
- tx  out  1  serial output, idle high
- rx  in  1  serial input, already synchronised externally

## Operation
- Register map, all accesses qualified by cs:
  - addr 0, read:
    - [7:0] rx FIFO head (0x00 when empty)
    - [8] rx_empty
    - [9] tx_full
    - [10] frame_err
    - [11] parity_err
    - [12] overrun
    - rest 0
  - addr 1, write: dvsr <= wr_data[DVSR_W-1:0].
  - addr 2, write: push wr_data[7:0] to tx FIFO. Ignored when full.
  - addr 3, write: pop rx FIFO. Ignored when empty.
  - addr 4, read/write: ctrl.
    - [0] data8 (1 = 8 bits, 0 = 7 bits)
    - [2:1] parity: 00 none, 01 even, 10 odd, 11 none
    - [3] two stop bits
    - [4] loopback (see Configuration)
  - addr 5, write: write-1-to-clear error flags. wr_data[0] clears frame_err, [1] parity_err, [2] overrun.
  - addr 6, read: {rx_level, tx_level}. Each level is FIFO_DEPTH_BIT+1 bits; rx_level occupies [31:16], tx_level [15:0], zero-extended.
  - other addresses: read 0, writes ignored.
- Baud tick generator:
  - Free-running counter; one-cycle tick when counter == dvsr, then counter returns to 0.
  - Tick period = dvsr+1 clocks. One bit = 16 ticks.
- TX FSM, states IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE.
  - In IDLE with tx FIFO non-empty: pop the head, latch ctrl, enter START.
  - LSB first. In 7-bit mode bit 7 is not sent.
  - Parity is computed over the sent bits; odd parity inverts it.
  - STOP lasts 16 or 32 ticks.
- RX FSM, states IDLE → START → DATA → PARITY → STOP → IDLE.
  - In IDLE, rx low latches ctrl and enters START.
  - START: after 7 ticks rx is resampled. High means glitch, return to IDLE with no flag.
  - Data, parity and stop bits are sampled every 16 ticks after that.
  - Only the first stop bit is checked. Stop = 0 sets frame_err.
  - Parity mismatch sets parity_err.
  - At the end of STOP the byte is pushed (7-bit mode: bit 7 = 0), even when errors were flagged.
  - If the rx FIFO is full at that point, the byte is dropped and overrun is set.
- ctrl and dvsr writes mid-frame take effect from the next frame. ctrl is latched per frame.

## Timing
- Reset values:
  - tx = 1, rd_data reflects empty FIFOs (0x100 at addr 0)
  - dvsr = 0, ctrl = 0, all flags 0
  - FIFOs empty, both FSMs IDLE, tick counter 0
- Register writes take effect on the clock edge of the write cycle. Reads are combinational in the same cycle.
- FIFO push/pop: level updates the cycle after the write.
  - Simultaneous push and pop on a non-empty FIFO: both occur, level unchanged.
  - Full + push + pop: both occur.
  - Empty + push + pop: push only.
- TX start latency: tx falls within 2 clocks of the first tick after the FIFO becomes non-empty.
- Frame length in ticks: 16 × (1 + data bits + parity bit) + 16 or 32 stop ticks.
- Rx push occurs on the tick that ends STOP; rx_empty deasserts the next cycle.
- Flag set and W1C clear in the same cycle: set wins.
- Reset asserted mid-frame: immediate return to reset state, tx high, no partial byte pushed.

## Configuration
- UART_LOOPBACK_EN defined:
  - ctrl[4] = 1 feeds the transmitter serial stream to the receiver in place of rx.
  - The tx pin is held at 1 while loopback is set.
- UART_LOOPBACK_EN undefined:
  - ctrl[4] is not stored and reads 0.
  - The receiver always uses rx.

## Test plan
- Reset, read addr 0 → 0x00000100. Read addr 6 → 0. tx = 1.
- dvsr = 3, ctrl = 0x01, push 0xA5 → tx low 64 clocks, then bits 1,0,1,0,0,1,0,1 of 64 clocks each, then high. tx_level returns to 0 after the pop.
- ctrl = 0x03 (8 bits, even parity), drive rx with 0x0F and correct parity, then a second frame with the parity bit flipped:
  - Two bytes are read out.
  - parity_err = 1 only after the second frame.
  - W1C 0x2 clears it.
- 8-bit mode, drive a frame whose stop bit is 0 → byte pushed, frame_err = 1.
- 1-tick rx glitch at 16x rate → no byte pushed, no flag set.
- Overrun and level checks:
  - Receive 2**FIFO_DEPTH_BIT + 1 bytes without popping → rx_level = 16 (default params), overrun = 1, the last byte is discarded.
  - With UART_LOOPBACK_EN defined: ctrl = 0x11, push 0x3C → rx head = 0x3C, tx pin stays 1.
